reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised successor to the processor's 16x16 register file. It provides:
- two asynchronous read ports and one synchronous write port;
- immediate substitution on read port 2, with zero or sign extension;
- write-to-read bypass;
- a per-register pending-write scoreboard that flags RAW/WAW hazards to the issue logic.

It sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W
IMM_W, 4, immediate field width; legal range 1..DATA_W
ZERO_REG, 0, when 1 register 0 reads as zero, ignores writes and is never reserved

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
rd_addr1  in  ADDR_W  read port 1 index
rd_addr2  in  ADDR_W  read port 2 index
imm_sel  in  1  1: port 2 returns the extended immediate instead of a register
imm_val  in  IMM_W  immediate field
imm_sext  in  1  1: sign-extend imm_val; 0: zero-extend
rsv_en  in  1  issue reserves a destination register (marks it pending)
rsv_addr  in  ADDR_W  destination register being reserved
rd_data1  out  DATA_W  read data 1
rd_data2  out  DATA_W  read data 2 or immediate
busy1  out  1  operand 1 not yet available
busy2  out  1  operand 2 not yet available
hazard  out  1  issue must stall this cycle
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: on rst_n low, immediately (asynchronously) clear all registers to 0, all pending bits to 0 and pend_cnt to 0. With the read addresses at 0 during reset:
  - rd_data1 = rd_data2 = 0 (with imm_sel=0);
  - busy1 = busy2 = hazard = 0.
- Reset mid-operation discards all reservations.
- Write: at posedge clk with wr_en=1, reg[wr_addr] <= wr_data. Ignored when ZERO_REG=1 and wr_addr=0.
- Read (combinational, zero-cycle latency):
  - rd_dataN = reg[rd_addrN], or wr_data when wr_en=1 and wr_addr == rd_addrN (bypass).
  - Bypass is suppressed for address 0 when ZERO_REG=1; that case returns 0.
- Immediate: imm_sel=1 makes rd_data2 = imm_val extended to DATA_W.
  - imm_sext=1: replicate imm_val[IMM_W-1].
  - imm_sext=0: pad with zeros.
  - IMM_W = DATA_W: pass imm_val through unchanged.
- Scoreboard (pend[i], one bit per register), updated at posedge clk:
  - rsv_en sets pend[rsv_addr].
  - wr_en clears pend[wr_addr].
  - Same address in the same cycle: set wins, because a new producer is issued while the old one retires.
  - Clearing an already-clear bit, or setting an already-set bit, is a no-op for the bit and for the count.
  - ZERO_REG=1: reservations of address 0 are ignored.
- busyN = pend[rd_addrN] & ~(wr_en & wr_addr == rd_addrN). Forced 0 for address 0 when ZERO_REG=1. busy2 is forced 0 when imm_sel=1.
- hazard = busy1 | busy2 | (rsv_en & pend[rsv_addr] & ~(wr_en & wr_addr == rsv_addr)).
  - The last term flags WAW.
  - hazard is advisory only: the block still performs the reservation when rsv_en=1. Issue logic must hold rsv_en low while hazard=1.
- pend_cnt tracks the population count of pend:
  - +1 on an effective set;
  - -1 on an effective clear;
  - unchanged when both occur on different addresses and both are effective;
  - never wraps, because the maximum is 2**ADDR_W, which fits in ADDR_W+1 bits.

Test Plan:
- Reset, then read all 16 registers (defaults) -> every rd_data = 0x0000, pend_cnt = 0, hazard = 0. Then assert rst_n low mid-sequence with 3 pending -> pend_cnt = 0 immediately, without waiting for a clock edge.
- Write 0xBEEF to r5; in the same cycle set rd_addr1 = 5 -> rd_data1 = 0xBEEF via bypass. Next cycle, wr_en=0 -> still 0xBEEF from storage.
- imm_sel=1, imm_val=4'hA: imm_sext=1 -> rd_data2 = 0xFFFA; imm_sext=0 -> 0x000A; busy2 = 0 even if pend[rd_addr2] = 1.
- rsv r3; next cycle read r3 -> busy1 = 1, hazard = 1, pend_cnt = 1. Writeback r3 = 0x1234 -> same cycle busy1 = 0, rd_data1 = 0x1234. Next cycle pend_cnt = 0.
- Same cycle rsv_en r7 and wr_en r7 with pend[7] = 1 -> pend[7] stays 1, pend_cnt unchanged, hazard = 0. rsv r7 again with no write -> hazard = 1 (WAW).
- ZERO_REG=1: write 0x5555 to r0, rsv r0 -> rd_data1 (addr 0) = 0, pend_cnt = 0, busy1 = 0. Reserve all 15 other registers -> pend_cnt = 15.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Bus between decode/issue, writeback and the register file.
// The master side (issue + writeback) drives addresses, data and reservations.
// The slave side (register file) returns read data and hazard status.
interface reg_file_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              imm_sel;
  logic [IMM_W-1:0]  imm_val;
  logic              imm_sext;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic              hazard;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
           imm_sel, imm_val, imm_sext, rsv_en, rsv_addr,
    input  rd_data1, rd_data2, busy1, busy2, hazard, pend_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
           imm_sel, imm_val, imm_sext, rsv_en, rsv_addr,
    output rd_data1, rd_data2, busy1, busy2, hazard, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port,
// write-to-read bypass, immediate substitution on port 2 and a
// per-register pending-write scoreboard for RAW/WAW hazard detection.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int IMM_W    = 4,
  parameter int ZERO_REG = 0
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic              eff_set;
  logic              eff_clr;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1;
  logic              busy2;
  logic              waw;

  // Register 0 is hard-wired to zero when ZERO_REG is set, so it takes no writes or reservations.
  assign wr_ok  = bus.wr_en  && !(ZR && bus.wr_addr  == '0);
  assign set_ok = bus.rsv_en && !(ZR && bus.rsv_addr == '0);

  // A set on an already pending bit changes nothing; a clear only counts if the
  // bit was pending and is not being re-reserved by the same-cycle set.
  assign eff_set = set_ok && !pend[bus.rsv_addr];
  assign eff_clr = bus.wr_en && pend[bus.wr_addr] &&
                   !(set_ok && bus.rsv_addr == bus.wr_addr);

  // Immediate extension; a full-width immediate passes straight through.
  generate
    if (IMM_W >= DATA_W) begin : g_imm_full
      assign imm_ext = DATA_W'(bus.imm_val);
    end else begin : g_imm_ext
      assign imm_ext = {{(DATA_W-IMM_W){bus.imm_sext & bus.imm_val[IMM_W-1]}}, bus.imm_val};
    end
  endgenerate

  // Next scoreboard state: clear on writeback first so a same-address reservation wins.
  always_comb begin
    pend_nxt = pend;
    if (bus.wr_en) pend_nxt[bus.wr_addr] = 1'b0;
    if (set_ok)    pend_nxt[bus.rsv_addr] = 1'b1;
    case ({eff_set, eff_clr})
      2'b10:   cnt_nxt = cnt + (ADDR_W+1)'(1);
      2'b01:   cnt_nxt = cnt - (ADDR_W+1)'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard bits and their population count; reset drops all reservations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Read ports with bypass from the writeback bus and operand-availability flags.
  always_comb begin
    rd1   = regs[bus.rd_addr1];
    rd2   = regs[bus.rd_addr2];
    busy1 = pend[bus.rd_addr1] && !(bus.wr_en && bus.wr_addr == bus.rd_addr1);
    busy2 = pend[bus.rd_addr2] && !(bus.wr_en && bus.wr_addr == bus.rd_addr2);
    if (bus.wr_en && bus.wr_addr == bus.rd_addr1) rd1 = bus.wr_data;
    if (bus.wr_en && bus.wr_addr == bus.rd_addr2) rd2 = bus.wr_data;
    if (ZR && bus.rd_addr1 == '0) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
    if (ZR && bus.rd_addr2 == '0) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
    if (bus.imm_sel) begin
      rd2   = imm_ext;
      busy2 = 1'b0;
    end
    waw = bus.rsv_en && pend[bus.rsv_addr] &&
          !(bus.wr_en && bus.wr_addr == bus.rsv_addr);
  end

  assign bus.rd_data1 = rd1;
  assign bus.rd_data2 = rd2;
  assign bus.busy1    = busy1;
  assign bus.busy2    = busy2;
  assign bus.hazard   = busy1 | busy2 | waw;
  assign bus.pend_cnt = cnt;
endmodule
